tt_um_warriorjacq9: RTL and testbench

TT_UM_WARRIORJACQ9 -- requirements
Module: tt_um_warriorjacq9

---
 rtl/tt_um_warriorjacq9.sv | 111 +++++++++++
 tb/tb_tt_um_warriorjacq9.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tt_um_warriorjacq9.sv
// rtl/tt_um_warriorjacq9.sv - tiny 4-bit ADDI/ADD sequencer that fetches operands over a request bus
// Each instruction walks FETCH -> REQA [-> REQN -> REQB] -> EXEC -> DONE and repeats forever.
module tt_um_warriorjacq9 (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;

  localparam logic [3:0] REQ_IDLE = 4'b0000;
  localparam logic [3:0] REQ_REG  = 4'b0001;
  localparam logic [3:0] REQ_NEXT = 4'b0011;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    REQA  = 3'd1,
    REQN  = 3'd2,
    REQB  = 3'd3,
    EXEC  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] opcode;
  logic [3:0] field;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] idx;
  logic [3:0] result;
  logic       carry;
  logic       done;
  logic [4:0] sum;

  logic unused;
  assign unused = &{1'b0, ena, uio_in[7:4]};

  // ADDI adds the immediate held in the operand field; ADD adds the second fetched register.
  assign sum = {1'b0, a} + {1'b0, (opcode == OP_ADDI) ? field : b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      opcode <= 4'd0;
      field  <= 4'd0;
      a      <= 4'd0;
      b      <= 4'd0;
      idx    <= 4'd0;
      result <= 4'd0;
      carry  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        FETCH: begin
          opcode <= ui_in[3:0];
          field  <= ui_in[7:4];
        end
        REQA: a   <= uio_in[3:0];
        REQN: idx <= ui_in[7:4];
        REQB: b   <= uio_in[3:0];
        EXEC: {carry, result} <= sum;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    uo_out     = 8'h00;
    uio_oe     = 8'hFF;
    done       = 1'b0;
    case (state)
      FETCH: begin
        if (ui_in[3:0] == OP_ADDI || ui_in[3:0] == OP_ADD) state_next = REQA;
      end
      REQA: begin
        uo_out     = {(opcode == OP_ADDI) ? 4'd1 : field, REQ_REG};
        uio_oe     = 8'hF0;
        state_next = (opcode == OP_ADDI) ? EXEC : REQN;
      end
      REQN: begin
        uo_out     = {4'd0, REQ_NEXT};
        state_next = REQB;
      end
      REQB: begin
        uo_out     = {idx, REQ_REG};
        uio_oe     = 8'hF0;
        state_next = EXEC;
      end
      EXEC: begin
        uo_out     = {4'd0, REQ_IDLE};
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  assign uio_out = {done, 2'b00, carry, result};

endmodule

// File: tb/tb_tt_um_warriorjacq9.sv
// tb/tb_tt_um_warriorjacq9.sv - directed and randomized bench with a bus responder and register-file model
module tb_tt_um_warriorjacq9;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int errors;

  logic [3:0] regs [16];
  logic [3:0] nxt_op;
  logic [3:0] last_res;
  logic       last_c;

  tt_um_warriorjacq9 dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus side: answer whatever the DUT is requesting right now.
  task automatic respond();
    logic [3:0] noise;
    noise = 4'($urandom);
    if (uo_out[3:0] == 4'b0001) uio_in = {noise, regs[uo_out[7:4]]};
    else uio_in = 8'($urandom);
    if (uo_out[3:0] == 4'b0011) ui_in = {nxt_op, ui_in[3:0]};
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge while the DUT sits in FETCH; leaves at the following FETCH.
  task automatic run_instr(input logic [7:0] instr, input logic [3:0] nxt);
    logic [3:0] op, fld;
    logic [3:0] ec[$];
    logic [3:0] ei[$];
    int total, n, exp_n;
    bit seen;
    op = instr[3:0];
    fld = instr[7:4];
    nxt_op = nxt;
    ui_in = instr;
    check("fetch_req", uo_out[3:0], 4'h0);
    check("fetch_oe", uio_oe, 8'hFF);
    if (op == 4'b0001) begin
      total = int'(regs[1]) + int'(fld);
      ec = '{4'h1, 4'h0};
      ei = '{4'h1, 4'h0};
      exp_n = 4;
    end else begin
      total = int'(regs[fld]) + int'(regs[nxt]);
      ec = '{4'h1, 4'h3, 4'h1, 4'h0};
      ei = '{fld, 4'h0, nxt, 4'h0};
      exp_n = 6;
    end
    n = 1;
    seen = 0;
    while (!seen && n < 12) begin
      step();
      n++;
      if (uio_out[7]) seen = 1;
      else begin
        if (n - 2 < ec.size()) begin
          check("req_code", uo_out[3:0], ec[n-2]);
          check("req_oe", uio_oe, (ec[n-2] == 4'h1) ? 8'hF0 : 8'hFF);
          if (ec[n-2] == 4'h1) check("req_idx", uo_out[7:4], ei[n-2]);
        end
        respond();
      end
    end
    check("done_seen", 32'(seen), 1);
    check("period", n, exp_n);
    check("result", uio_out[3:0], total % 16);
    check("carry", uio_out[4], 32'(total > 15));
    check("pad", uio_out[6:5], 2'b00);
    check("done_oe", uio_oe, 8'hFF);
    last_res = 4'(total % 16);
    last_c = (total > 15);
    step();
    check("done_width", uio_out[7], 1'b0);
    check("hold", uio_out[4:0], {last_c, last_res});
  endtask

  task automatic run_nop(input logic [7:0] instr, input int cycles);
    ui_in = instr;
    for (int i = 0; i < cycles; i++) begin
      step();
      check("nop_uo", uo_out, 8'h00);
      check("nop_out", uio_out, {3'b000, last_c, last_res});
      check("nop_oe", uio_oe, 8'hFF);
    end
  endtask

  initial begin
    logic [3:0] rop;
    checks = 0;
    errors = 0;
    ena = 1'b1;
    rst_n = 1'b0;
    ui_in = 8'h00;
    uio_in = 8'h00;
    nxt_op = 4'h0;
    last_res = 4'h0;
    last_c = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 4'($urandom);

    repeat (3) @(negedge clk);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;

    regs[1] = 4'd4;
    run_instr(8'h21, 4'h0);
    run_instr(8'h31, 4'h0);
    run_instr(8'h12, 4'h1);
    run_instr(8'hF1, 4'h0);
    run_nop(8'h00, 4);
    run_nop(8'h57, 4);

    // Abort an ADD while it waits in REQB.
    regs[3] = 4'd9;
    regs[5] = 4'd2;
    ui_in = 8'h32;
    nxt_op = 4'h5;
    step(); respond();
    step(); respond();
    step();
    check("abort_in_reqb", uo_out, 8'h51);
    rst_n = 1'b0;
    #1;
    check("abort_uo", uo_out, 8'h00);
    check("abort_uio_out", uio_out, 8'h00);
    check("abort_oe", uio_oe, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", uio_out[7], 1'b0);
    end
    rst_n = 1'b1;
    last_res = 4'h0;
    last_c = 1'b0;
    run_nop(8'h00, 2);
    run_instr(8'h32, 4'h5);

    for (int t = 0; t < 24; t++) begin
      regs[$urandom_range(0, 15)] = 4'($urandom);
      case ($urandom_range(0, 2))
        0: run_instr({4'($urandom), 4'h1}, 4'h0);
        1: run_instr({4'($urandom), 4'h2}, 4'($urandom));
        default: begin
          rop = 4'($urandom);
          if (rop == 4'h1 || rop == 4'h2) rop = 4'hA;
          run_nop({4'($urandom), rop}, 3);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
